// File: rtl/leg_wbuf_pkg.sv
// rtl/leg_wbuf_pkg.sv - shared types for the data-side posted-write buffer
package leg_wbuf_pkg;

    // Entry widths; the top-level AW/DW parameters must match these.
    localparam int WBUF_AW = 32;
    localparam int WBUF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic [WBUF_AW-3:0] addr;
        logic [WBUF_DW-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// rtl/write_buffer_fifo.sv - circular word-write FIFO with parallel address match
module write_buffer_fifo
    import leg_wbuf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  wbuf_entry_t        i_entry,
    input  logic               i_pop,
    input  logic [WBUF_AW-3:0] i_match_addr,
    output wbuf_entry_t        o_head,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_hit
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    wbuf_entry_t      r_mem [DEPTH];
    logic [PW:0]      w_count;
    logic [DEPTH-1:0] w_valid;

    assign w_count = r_wptr - r_rptr;
    assign o_empty = (w_count == '0);
    assign o_full  = (w_count == (PW+1)'(DEPTH));
    assign o_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[PW-1:0]] <= i_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_valid = '0;
        o_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PW'(i) - r_rptr[PW-1:0]} < w_count);
            if (w_valid[i] && (r_mem[i].addr == i_match_addr)) o_hit = 1'b1;
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// rtl/data_write_buffer.sv - posted-write buffer between data cache and AHB data port
module data_write_buffer
    import leg_wbuf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = WBUF_AW,
    parameter int DW    = WBUF_DW
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          CReq,
    input  logic          CWrite,
    input  logic [AW-1:0] CAddr,
    input  logic [DW-1:0] CWData,
    output logic          CReady,
    output logic [DW-1:0] CRData,
    output logic          BReq,
    output logic          BWrite,
    output logic [AW-1:0] BAddr,
    output logic [DW-1:0] BWData,
    input  logic          BReady,
    input  logic [DW-1:0] BRData,
    output logic          Empty,
    output logic          Full
);

    wbuf_state_e r_state;
    wbuf_state_e w_next;
    wbuf_entry_t w_wr_entry;
    wbuf_entry_t w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_hit;
    logic        w_rd_req;
    logic        w_wr_acc;
    logic        w_pop;
    logic        w_rd_done;

    assign w_wr_entry = '{addr: CAddr[AW-1:2], data: CWData};
    assign w_rd_req   = CReq & ~CWrite;
    assign w_wr_acc   = CReq & CWrite & ~w_full;
    assign w_pop      = (r_state == ST_DRAIN) & BReady;
    assign w_rd_done  = (r_state == ST_READ) & BReady;

    write_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .i_push      (w_wr_acc),
        .i_entry     (w_wr_entry),
        .i_pop       (w_pop),
        .i_match_addr(CAddr[AW-1:2]),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_hit       (w_hit)
    );

    // Reads win over draining unless they hit a buffered word, which must reach memory first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_req && !w_hit) w_next = ST_READ;
                else if (!w_empty)      w_next = ST_DRAIN;
            end
            ST_READ:  if (BReady) w_next = ST_IDLE;
            ST_DRAIN: if (BReady) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        BReq   = 1'b0;
        BWrite = 1'b0;
        BAddr  = '0;
        BWData = '0;
        case (r_state)
            ST_READ: begin
                BReq  = 1'b1;
                BAddr = CAddr;
            end
            ST_DRAIN: begin
                BReq   = 1'b1;
                BWrite = 1'b1;
                BAddr  = {w_head.addr, 2'b00};
                BWData = w_head.data;
            end
            default: ;
        endcase
    end

    assign CReady = w_wr_acc | w_rd_done;
    assign CRData = w_rd_done ? BRData : '0;
    assign Empty  = w_empty;
    assign Full   = w_full;

endmodule

// File: tb/tb_data_write_buffer.sv
// tb/tb_data_write_buffer.sv - self-checking bench for data_write_buffer
module tb_data_write_buffer;

    localparam int DEPTH = 8;

    logic        HCLK;
    logic        HRESETn;
    logic        CReq;
    logic        CWrite;
    logic [31:0] CAddr;
    logic [31:0] CWData;
    logic        CReady;
    logic [31:0] CRData;
    logic        BReq;
    logic        BWrite;
    logic [31:0] BAddr;
    logic [31:0] BWData;
    logic        BReady;
    logic [31:0] BRData;
    logic        Empty;
    logic        Full;

    data_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .CReq(CReq), .CWrite(CWrite), .CAddr(CAddr), .CWData(CWData),
        .CReady(CReady), .CRData(CRData),
        .BReq(BReq), .BWrite(BWrite), .BAddr(BAddr), .BWData(BWData),
        .BReady(BReady), .BRData(BRData),
        .Empty(Empty), .Full(Full)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Bus-side memory and transaction log
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } blog_t;
    blog_t       blog[$];
    logic [31:0] mem [logic [31:0]];

    bit bus_en  = 1'b0;
    int bus_lat = 0;
    int bcnt    = 0;

    always @(posedge HCLK) begin
        #1;
        if (BReq && bus_en && bcnt >= bus_lat) begin
            BReady = 1'b1;
            BRData = (!BWrite && mem.exists(BAddr)) ? mem[BAddr] : 32'h0;
            bcnt   = 0;
        end else begin
            BReady = 1'b0;
            BRData = 32'h0;
            if (BReq) bcnt++;
            else      bcnt = 0;
        end
    end

    // Reference model: a queue of posted writes plus the current bus activity (0 none, 1 read, 2 writeback)
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          m_phase = 0;
    int          m_nph;
    bit          e_full, e_empty, e_acc, e_breq, e_bwrite, e_crdy, m_hz;
    logic [31:0] e_baddr, e_bwdata, e_crdata;

    always @(negedge HRESETn) begin
        mq.delete();
        m_phase = 0;
    end

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            mq.delete();
            m_phase = 0;
        end else begin
            e_full   = (mq.size() == DEPTH);
            e_empty  = (mq.size() == 0);
            e_acc    = CReq && CWrite && !e_full;
            e_breq   = (m_phase != 0);
            e_bwrite = (m_phase == 2);
            e_baddr  = (m_phase == 1) ? CAddr : (m_phase == 2) ? mq[0].addr : 32'h0;
            e_bwdata = (m_phase == 2) ? mq[0].data : 32'h0;
            e_crdy   = e_acc || (m_phase == 1 && BReady);
            e_crdata = (m_phase == 1 && BReady) ? BRData : 32'h0;

            chk("m_CReady", {31'b0, CReady}, {31'b0, e_crdy});
            chk("m_CRData", CRData, e_crdata);
            chk("m_BReq",   {31'b0, BReq},   {31'b0, e_breq});
            chk("m_Empty",  {31'b0, Empty},  {31'b0, e_empty});
            chk("m_Full",   {31'b0, Full},   {31'b0, e_full});
            chk("m_BAddr",  BAddr, e_baddr);
            if (e_breq)       chk("m_BWrite", {31'b0, BWrite}, {31'b0, e_bwrite});
            if (m_phase != 1) chk("m_BWData", BWData, e_bwdata);

            if (BReq && BReady) begin
                blog.push_back('{wr: BWrite, addr: BAddr, data: BWrite ? BWData : CRData});
                if (BWrite) mem[BAddr] = BWData;
            end

            m_hz = 1'b0;
            foreach (mq[i]) if (mq[i].addr[31:2] == CAddr[31:2]) m_hz = 1'b1;
            m_nph = m_phase;
            case (m_phase)
                0: begin
                    if (CReq && !CWrite && !m_hz) m_nph = 1;
                    else if (mq.size() > 0)       m_nph = 2;
                end
                1: if (BReady) m_nph = 0;
                default: if (BReady) begin
                    void'(mq.pop_front());
                    m_nph = 0;
                end
            endcase
            m_phase = m_nph;
            if (e_acc) mq.push_back('{addr: CAddr & ~32'h3, data: CWData});
        end
    end

    // Tasks start and end at posedge+1
    task automatic cache_write(input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        CReq = 1'b1; CWrite = 1'b1; CAddr = a; CWData = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge HCLK);
            got = CReady;
            @(posedge HCLK); #1;
            if (got) break;
        end
        CReq = 1'b0; CWrite = 1'b0; CWData = 32'h0;
        chk("write_accept", {31'b0, got}, 32'd1);
    endtask

    task automatic cache_read(input logic [31:0] a, output logic [31:0] d);
        bit got = 1'b0;
        d = 32'hx;
        CReq = 1'b1; CWrite = 1'b0; CAddr = a;
        for (int n = 0; n < 300; n++) begin
            @(negedge HCLK);
            got = CReady;
            if (got) d = CRData;
            @(posedge HCLK); #1;
            if (got) break;
        end
        CReq = 1'b0;
        chk("read_complete", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_empty();
        bit e = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge HCLK);
            e = Empty && !BReq;
            @(posedge HCLK); #1;
            if (e) break;
        end
        chk("drain_to_empty", {31'b0, e}, 32'd1);
    endtask

    task automatic chk_log(input string nm, input int idx, input bit wr, input logic [31:0] a);
        if (idx < blog.size()) begin
            chk({nm, "_wr"}, {31'b0, blog[idx].wr}, {31'b0, wr});
            chk({nm, "_addr"}, blog[idx].addr, a);
        end else begin
            chk({nm, "_present"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    int          mark;
    logic [31:0] rd;
    bit          seen;

    initial begin
        HRESETn = 1'b0; CReq = 1'b0; CWrite = 1'b0; CAddr = 32'h0; CWData = 32'h0;
        BReady = 1'b0; BRData = 32'h0;
        mem[32'h400] = 32'h12345678;
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        @(negedge HCLK);
        chk("rst_Empty",  {31'b0, Empty},  32'd1);
        chk("rst_Full",   {31'b0, Full},   32'd0);
        chk("rst_BReq",   {31'b0, BReq},   32'd0);
        chk("rst_BWrite", {31'b0, BWrite}, 32'd0);
        chk("rst_CReady", {31'b0, CReady}, 32'd0);
        chk("rst_BAddr",  BAddr,  32'h0);
        chk("rst_BWData", BWData, 32'h0);
        chk("rst_CRData", CRData, 32'h0);
        @(posedge HCLK); #1;

        // Single posted write then drain
        bus_en = 1'b1; bus_lat = 1;
        cache_write(32'h100, 32'hAAAA0001);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge HCLK);
            if (BReq) begin
                seen = 1'b1;
                chk("wr1_BWrite", {31'b0, BWrite}, 32'd1);
                chk("wr1_BAddr",  BAddr,  32'h100);
                chk("wr1_BWData", BWData, 32'hAAAA0001);
            end
            @(posedge HCLK); #1;
            if (seen) break;
        end
        chk("wr1_breq_seen", {31'b0, seen}, 32'd1);
        wait_empty();
        @(negedge HCLK);
        chk("wr1_Empty", {31'b0, Empty}, 32'd1);
        @(posedge HCLK); #1;

        // Fill to DEPTH with the bus stalled, then a 9th write waits for one pop
        bus_en = 1'b0; bus_lat = 0;
        mark = blog.size();
        for (int i = 0; i < 8; i++) cache_write(32'h200 + 32'(4 * i), 32'hF000_0000 + 32'(i));
        @(negedge HCLK);
        chk("fill_Full", {31'b0, Full}, 32'd1);
        @(posedge HCLK); #1;
        CReq = 1'b1; CWrite = 1'b1; CAddr = 32'h220; CWData = 32'h0000_0099;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk("full_stall", {31'b0, CReady}, 32'd0);
            if (k == 2) bus_en = 1'b1;
            @(posedge HCLK); #1;
        end
        @(negedge HCLK);
        chk("pop_cycle_BReady", {31'b0, BReady}, 32'd1);
        chk("pop_cycle_no_accept", {31'b0, CReady}, 32'd0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("accept_after_pop", {31'b0, CReady}, 32'd1);
        @(posedge HCLK); #1;
        CReq = 1'b0; CWrite = 1'b0;
        wait_empty();
        for (int i = 0; i < 9; i++) chk_log("fill_order", mark + i, 1'b1, 32'h200 + 32'(4 * i));

        // Read arriving during a drain bypasses the remaining buffered writes
        bus_lat = 4;
        mark = blog.size();
        cache_write(32'h2F0, 32'h11);
        cache_write(32'h300, 32'h22);
        cache_write(32'h304, 32'h33);
        cache_read(32'h400, rd);
        chk("bypass_rdata", rd, 32'h12345678);
        wait_empty();
        chk_log("bypass0", mark + 0, 1'b1, 32'h2F0);
        chk_log("bypass1", mark + 1, 1'b0, 32'h400);
        chk_log("bypass2", mark + 2, 1'b1, 32'h300);
        chk_log("bypass3", mark + 3, 1'b1, 32'h304);

        // Read hazarding a buffered word waits for it (and older writes) to drain
        bus_lat = 3;
        mark = blog.size();
        cache_write(32'h4F0, 32'h1);
        cache_write(32'h500, 32'hDEAD);
        cache_read(32'h500, rd);
        chk("hazard_rdata", rd, 32'hDEAD);
        chk_log("hazard0", mark + 0, 1'b1, 32'h4F0);
        chk_log("hazard1", mark + 1, 1'b1, 32'h500);
        chk_log("hazard2", mark + 2, 1'b0, 32'h500);
        wait_empty();

        // Reset in the middle of a stalled drain with 5 entries queued
        bus_en = 1'b0; bus_lat = 0;
        for (int i = 0; i < 5; i++) cache_write(32'h600 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        @(negedge HCLK);
        chk("pre_rst_BReq",  {31'b0, BReq},  32'd1);
        chk("pre_rst_Empty", {31'b0, Empty}, 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_BReq",   {31'b0, BReq},   32'd0);
        chk("async_rst_BWrite", {31'b0, BWrite}, 32'd0);
        chk("async_rst_Empty",  {31'b0, Empty},  32'd1);
        chk("async_rst_Full",   {31'b0, Full},   32'd0);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        bus_en = 1'b1;
        mark = blog.size();
        repeat (20) @(posedge HCLK);
        #1;
        chk("no_stale_bus", 32'(blog.size() - mark), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-write buffer between the data cache's bus port and the AHB arbiter's data-side port. It absorbs word writebacks from the data cache without stalling the cache, then drains them to the bus when the bus is idle. Cache read misses bypass queued writes unless their address matches a buffered entry. This shortens the data-side miss penalty while preserving read-after-write ordering to the same word.

## Interface
Parameters:
- DEPTH, 8, number of word entries; power of two, ≥2
- AW, 32, address width
- DW, 32, data width

Ports:
- HCLK  in  1  clock; single clock domain
- HRESETn  in  1  asynchronous, active-low reset
- CReq  in  1  cache request valid; held until CReady
- CWrite  in  1  1 = write, 0 = read
- CAddr  in  AW  cache word address; stable while CReq
- CWData  in  DW  cache write data
- CReady  out  1  write accepted, or read data valid, this cycle
- CRData  out  DW  read data to cache
- BReq  out  1  bus request to arbiter
- BWrite  out  1  bus transfer is a write
- BAddr  out  AW  bus address
- BWData  out  DW  bus write data
- BReady  in  1  bus transfer complete this cycle; BRData valid for reads
- BRData  in  DW  bus read data
- Empty  out  1  no buffered entries
- Full  out  1  count == DEPTH

## Operation
- Storage: circular FIFO of {addr[AW-1:2], data}. Pointers are log2(DEPTH)+1 bits; the MSB disambiguates full from empty.
- Write accept: when CReq&CWrite and count<DEPTH, the write is enqueued and CReady=1 combinationally in the same cycle.
  - When full, CReady=0 and the cache holds the request.
  - A write presented while full is not accepted in the cycle a drain pops. It is accepted the next cycle.
- Hazard: a read hazards when CAddr[AW-1:2] equals the address of any valid entry, including the entry currently draining.
- FSM states: IDLE, READ, DRAIN.
- IDLE transitions:
  - CReq & !CWrite & !hazard → READ.
  - Otherwise, !Empty → DRAIN.
  - Otherwise, stay in IDLE.
  - A pending read has priority over draining.
- READ:
  - BReq=1, BWrite=0, BAddr=CAddr.
  - On BReady: CReady=1 and CRData=BRData in the same cycle, then → IDLE.
- DRAIN:
  - BReq=1, BWrite=1, BAddr/BWData = head entry.
  - On BReady: pop the head, then → IDLE.
- Bus transactions are atomic. A read arriving during DRAIN waits for the drain to complete.
- A hazarded read waits. The FSM keeps draining until no entry matches, then issues the read.
- Enqueue may occur in any state, including DRAIN. A simultaneous enqueue and pop leaves count unchanged.
- In IDLE: BReq=0; BAddr and BWData are 0.
- CRData is 0 except during the READ completion cycle.

## Timing
- Reset (async assert, sync release) clears:
  - State=IDLE, pointers=0.
  - Empty=1, Full=0, CReady=0, BReq=0, BWrite=0.
  - BAddr=0, BWData=0, CRData=0.
- Reset mid-transaction: the current bus transfer is abandoned and all buffered writes are discarded.
- Write accept latency: 0 cycles, unless full.
- Read bus issue: BReq rises 1 cycle after CReq is first seen in IDLE with no hazard.
  - Total read latency = 1 + bus latency.
- Drain issue: BReq rises 1 cycle after the FSM enters IDLE with Empty=0 and no eligible read pending.
- Empty and Full are registered from the pointers and reflect the state after the previous edge.

## Structure
- Package leg_wbuf_pkg holds:
  - The state enum: IDLE, READ, DRAIN.
  - The entry struct: addr, data.
- Sub-module write_buffer_fifo contains:
  - Storage and pointers.
  - Full/Empty/count logic.
  - Parallel address-match (CAM) output `hit`.
- The top-level FSM and bus muxing live in data_write_buffer.

## Test plan
- Reset with DEPTH=8, then write 0xAAAA0001 to 0x100 → CReady=1 same cycle; the next cycle issues BReq/BWrite, BAddr=0x100, BWData=0xAAAA0001. After BReady, Empty=1.
- Fill: 8 writes to 0x200..0x21C with BReady held 0 → Full=1. The 9th write sees CReady=0 until one BReady pops an entry; it is accepted the following cycle.
- Read bypass: buffer holds 0x300 and 0x304; read 0x400 → BReq=1, BWrite=0, BAddr=0x400 before any drain. BRData=0x12345678 returns as CRData in the same cycle as CReady.
- Hazard: buffer holds 0x500=0xDEAD; read 0x500 → both the 0x500 write and any older writes drain first. Only then is the read issued, and CRData equals memory value 0xDEAD.
- Read arrives during DRAIN: the drain completes with BReady, then the read issues one cycle later. No entry is lost and count drops by 1.
- Assert HRESETn low mid-DRAIN with 5 entries → BReq=0 and Empty=1 immediately (asynchronously). After release, no stale write appears on the bus.
